// File: rtl/md_ctrl.sv
// Issue and hazard controller for the mul/div unit: decodes E-stage opcodes into
// unit strobes, shadows the unit's busy count and raises the D-stage stall.
module md_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] e_op,
  input  logic       d_md_use,
  input  logic       unit_busy,
  output logic       md_loen,
  output logic       md_hien,
  output logic       md_mdsel,
  output logic       md_unsigned,
  output logic       md_add,
  output logic       md_rdsel,
  output logic       md_stall,
  output logic [3:0] md_cnt,
  output logic       md_err
);

  // state | meaning
  // IDLE  | unit free, cnt = 0
  // MUL   | multiply/madd in flight, cnt counts down from MUL_LAT
  // DIV   | divide in flight, cnt counts down from DIV_LAT
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       armed;
  logic       idle;
  logic       is_mul;
  logic       is_div;
  logic       start;
  logic       wr_hi;
  logic       wr_lo;
  logic       illegal;
  logic       mismatch;

  always_comb begin
    idle        = (state == IDLE);
    is_mul      = (e_op == 4'd1) || (e_op == 4'd2) || (e_op == 4'd5) || (e_op == 4'd6);
    is_div      = (e_op == 4'd3) || (e_op == 4'd4);
    start       = (is_mul || is_div) && idle;
    wr_hi       = (e_op == 4'd7) && idle;
    wr_lo       = (e_op == 4'd8) && idle;
    // Any opcode that would touch the unit while it is occupied means the stall failed.
    illegal     = (is_mul || is_div || e_op == 4'd7 || e_op == 4'd8) && !idle;
    mismatch    = armed && ((!idle) != unit_busy);
    md_loen     = start || wr_lo;
    md_hien     = start || wr_hi;
    md_mdsel    = start && is_div;
    md_unsigned = start && ((e_op == 4'd2) || (e_op == 4'd4) || (e_op == 4'd6));
    md_add      = start && ((e_op == 4'd5) || (e_op == 4'd6));
    md_rdsel    = (e_op == 4'd9);
    md_stall    = d_md_use && (!idle || start || unit_busy);
    md_cnt      = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      armed  <= 1'b0;
      md_err <= 1'b0;
    end else begin
      if (start) begin
        state <= is_div ? DIV : MUL;
        cnt   <= is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
        armed <= 1'b1;
      end else if (!idle) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1)
          state <= IDLE;
      end
      if (illegal || mismatch)
        md_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a simple behavioural mul/div unit driving unit_busy.
module tb_md_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] e_op;
  logic       d_md_use;
  logic       unit_busy;
  logic       md_loen, md_hien, md_mdsel, md_unsigned, md_add, md_rdsel, md_stall, md_err;
  logic [3:0] md_cnt;
  logic [3:0] ucnt;
  logic       force_idle;
  int         n_chk = 0;
  int         n_err = 0;

  md_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .e_op(e_op), .d_md_use(d_md_use), .unit_busy(unit_busy),
    .md_loen(md_loen), .md_hien(md_hien), .md_mdsel(md_mdsel), .md_unsigned(md_unsigned),
    .md_add(md_add), .md_rdsel(md_rdsel), .md_stall(md_stall), .md_cnt(md_cnt), .md_err(md_err)
  );

  always #5 clk = ~clk;

  // Unit model: latches a start when free, then stays busy for the op latency.
  always @(posedge clk) begin
    if (reset) ucnt <= 4'd0;
    else if (ucnt != 4'd0) ucnt <= ucnt - 4'd1;
    else if (e_op >= 4'd1 && e_op <= 4'd6) ucnt <= (e_op == 4'd3 || e_op == 4'd4) ? 4'd10 : 4'd5;
  end
  assign unit_busy = (ucnt != 4'd0) && !force_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; e_op = 4'd0; d_md_use = 1'b0; force_idle = 1'b0;
    step(); step();
    reset = 1'b0; settle();
    chk("rst_cnt", md_cnt, 0);
    chk("rst_err", md_err, 0);
    chk("rst_stall", md_stall, 0);
    chk("rst_strobes", {md_loen, md_hien, md_mdsel, md_unsigned, md_add}, 0);

    // mult with d_md_use held
    step();
    e_op = 4'd1; d_md_use = 1'b1; settle();
    chk("mult_loen", md_loen, 1);
    chk("mult_hien", md_hien, 1);
    chk("mult_mdsel", md_mdsel, 0);
    chk("mult_stall_T", md_stall, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      e_op = 4'd0; settle();
      chk($sformatf("mult_cnt%0d", i), md_cnt, (i <= 5) ? 6 - i : 0);
      chk($sformatf("mult_stall%0d", i), md_stall, (i <= 5) ? 1 : 0);
    end
    chk("mult_err", md_err, 0);

    // divu issued in the first idle cycle
    e_op = 4'd4; settle();
    chk("divu_mdsel", md_mdsel, 1);
    chk("divu_unsigned", md_unsigned, 1);
    chk("divu_add", md_add, 0);
    chk("divu_stall_T", md_stall, 1);
    for (int i = 1; i <= 11; i++) begin
      step();
      e_op = 4'd0; settle();
      chk($sformatf("divu_cnt%0d", i), md_cnt, (i <= 10) ? 11 - i : 0);
      chk($sformatf("divu_stall%0d", i), md_stall, (i <= 10) ? 1 : 0);
    end

    // maddu then mult back-to-back
    e_op = 4'd6; settle();
    chk("maddu_add", md_add, 1);
    chk("maddu_unsigned", md_unsigned, 1);
    chk("maddu_loen", md_loen, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      e_op = 4'd0; settle();
      chk($sformatf("maddu_cnt%0d", i), md_cnt, 6 - i);
    end
    step();
    e_op = 4'd1; settle();
    chk("b2b_cnt", md_cnt, 0);
    chk("b2b_loen", md_loen, 1);
    chk("b2b_add", md_add, 0);
    chk("b2b_stall", md_stall, 1);
    step();
    e_op = 4'd0; settle();
    chk("b2b_cnt_next", md_cnt, 5);
    for (int i = 0; i < 5; i++) step();
    chk("b2b_idle", md_cnt, 0);
    chk("b2b_err", md_err, 0);

    // mthi / mflo / mfhi
    d_md_use = 1'b0;
    e_op = 4'd7; settle();
    chk("mthi_hien", md_hien, 1);
    chk("mthi_loen", md_loen, 0);
    chk("mthi_stall", md_stall, 0);
    step();
    chk("mthi_cnt", md_cnt, 0);
    e_op = 4'd8; settle();
    chk("mtlo_loen", md_loen, 1);
    chk("mtlo_hien", md_hien, 0);
    step();
    e_op = 4'd10; settle();
    chk("mflo_rdsel", md_rdsel, 0);
    chk("mflo_strobes", {md_loen, md_hien}, 0);
    step();
    e_op = 4'd9; settle();
    chk("mfhi_rdsel", md_rdsel, 1);
    step();
    e_op = 4'd0; settle();
    chk("rw_cnt", md_cnt, 0);
    chk("rw_err", md_err, 0);

    // illegal mtlo while in MUL
    e_op = 4'd1; settle();
    step();
    e_op = 4'd8; settle();
    chk("ill_cnt", md_cnt, 5);
    chk("ill_strobes", {md_loen, md_hien}, 0);
    chk("ill_stall_nouse", md_stall, 0);
    step();
    e_op = 4'd0; settle();
    chk("ill_err", md_err, 1);
    chk("ill_cnt_keep", md_cnt, 4);
    for (int i = 0; i < 6; i++) step();
    chk("ill_err_sticky", md_err, 1);
    reset = 1'b1; step(); reset = 1'b0; settle();
    chk("ill_err_clr", md_err, 0);

    // unit_busy drops during DIV
    e_op = 4'd3; settle();
    chk("div_mdsel", md_mdsel, 1);
    chk("div_unsigned", md_unsigned, 0);
    step();
    e_op = 4'd0; settle();
    chk("mis_pre_err", md_err, 0);
    force_idle = 1'b1; step();
    force_idle = 1'b0; settle();
    chk("mis_err", md_err, 1);
    for (int i = 0; i < 12; i++) step();
    chk("mis_err_sticky", md_err, 1);
    reset = 1'b1; step(); reset = 1'b0; settle();

    // reset mid-divide at cnt = 7
    e_op = 4'd4; settle();
    for (int i = 0; i < 4; i++) begin
      step();
      e_op = 4'd0;
    end
    d_md_use = 1'b1; settle();
    chk("mid_cnt7", md_cnt, 7);
    chk("mid_stall", md_stall, 1);
    reset = 1'b1; step(); reset = 1'b0; settle();
    chk("mid_rst_cnt", md_cnt, 0);
    chk("mid_rst_stall", md_stall, 0);
    chk("mid_rst_err", md_err, 0);
    step();
    chk("mid_rst_err2", md_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
